// File: rtl/accum_buf_drain_pkg.sv
// Shared parameters, FSM encoding and requantization helper for the result-store read path.
// The weight and gradient paths import requant_sat from here as well.
package accum_buf_drain_pkg;

  localparam int BATCH     = 4;
  localparam int RES_W     = 32;
  localparam int DEF_OUT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } drain_state_t;

  function automatic int bw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round-half-up arithmetic shift, then saturate to a signed out_w-bit range.
  // Extra headroom bit keeps the rounding add from overflowing.
  function automatic logic signed [RES_W-1:0] requant_sat(input logic signed [RES_W-1:0] x,
                                                          input int sh,
                                                          input int out_w);
    logic signed [RES_W:0] xe;
    logic signed [RES_W:0] rnd;
    logic signed [RES_W:0] y;
    logic signed [RES_W:0] satMax;
    logic signed [RES_W:0] satMin;
    xe     = {x[RES_W-1], x};
    satMax = (RES_W+1)'((64'sd1 <<< (out_w - 1)) - 64'sd1);
    satMin = -satMax - (RES_W+1)'(1);
    rnd    = '0;
    if (sh == 0) begin
      y = xe;
    end else if (sh >= RES_W) begin
      y = '0;
    end else begin
      rnd = (RES_W+1)'(1) <<< (sh - 1);
      y   = (xe + rnd) >>> sh;
    end
    if (y > satMax) begin
      y = satMax;
    end else if (y < satMin) begin
      y = satMin;
    end
    return y[RES_W-1:0];
  endfunction

endpackage

// File: rtl/accum_buf_drain_sync_fifo.sv
// Small synchronous circular FIFO with an occupancy count; read data is the head entry.
// Used as the skid buffer that absorbs reads still in flight when downstream stalls.
module sync_fifo
  import accum_buf_drain_pkg::*;
#(
  parameter  int DEPTH = 3,
  parameter  int WIDTH = 8,
  localparam int PTR_W = bw(DEPTH),
  localparam int CNT_W = bw(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_doPop  = i_pop && (r_count != '0);
  assign w_doPush = i_push && ((r_count != CNT_W'(DEPTH)) || w_doPop);
  assign o_rdata  = r_mem[r_rdPtr];
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= ptrInc(r_wrPtr);
      if (w_doPop)  r_rdPtr <= ptrInc(r_rdPtr);
      if (w_doPush && !w_doPop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_doPop && !w_doPush) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_wdata;
  end

endmodule

// File: rtl/accum_buf_drain.sv
// Walks an address range of the accumulation buffer, requantizes each row as it returns
// from the RAM, and streams rows out through a credit-protected skid FIFO.
module accum_buf_drain
  import accum_buf_drain_pkg::*;
#(
  parameter  int DEPTH      = 256,
  parameter  int RD_LAT     = 1,
  parameter  int FIFO_DEPTH = RD_LAT + 2,
  parameter  int OUT_W      = DEF_OUT_W,
  parameter  int SHIFT_W    = 5,
  localparam int ADDR_W     = bw(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [ADDR_W-1:0]      i_start_addr,
  input  logic [ADDR_W:0]        i_len,
  input  logic [SHIFT_W-1:0]     i_shift,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [ADDR_W-1:0]      o_rd_addr,
  input  logic [BATCH*RES_W-1:0] i_rd_data,
  output logic [BATCH*OUT_W-1:0] o_out_data,
  output logic                   o_out_valid,
  input  logic                   i_out_ready
);

  localparam int CNT_W = bw(FIFO_DEPTH + 1);

  drain_state_t             r_state;
  drain_state_t             w_nextState;
  logic [ADDR_W-1:0]        r_curAddr;
  logic [ADDR_W:0]          r_remain;
  logic [SHIFT_W-1:0]       r_shift;
  logic [RD_LAT-1:0]        r_tag;
  int                       w_inflight;
  logic                     w_issue;
  logic                     w_lastIssue;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_fifoEmpty;
  logic [CNT_W-1:0]         w_fifoCount;
  logic [BATCH*OUT_W-1:0]   w_reqData;
  logic signed [RES_W-1:0]  w_elem;

  always_comb begin
    w_inflight = 0;
    for (int i = 0; i < RD_LAT; i++) w_inflight += int'(r_tag[i]);
  end

  // A read is only issued when the FIFO is guaranteed a slot for it on return.
  assign w_issue     = (r_state == ST_ISSUE) && ((int'(w_fifoCount) + w_inflight) < FIFO_DEPTH);
  assign w_lastIssue = w_issue && (r_remain == (ADDR_W+1)'(1));
  assign w_push      = r_tag[RD_LAT-1];
  assign w_pop       = !w_fifoEmpty && i_out_ready;
  assign o_rd_addr   = r_curAddr;
  assign o_out_valid = !w_fifoEmpty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_curAddr <= '0;
      r_remain  <= '0;
      r_shift   <= '0;
      r_tag     <= '0;
    end else begin
      r_tag[0] <= w_issue;
      for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
      if (r_state == ST_IDLE && i_start) begin
        r_remain <= i_len;
        r_shift  <= i_shift;
        if (i_len != '0) r_curAddr <= i_start_addr;
      end else if (w_issue) begin
        r_curAddr <= (r_curAddr == ADDR_W'(DEPTH - 1)) ? '0 : r_curAddr + ADDR_W'(1);
        r_remain  <= r_remain - (ADDR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_nextState = (i_len != '0) ? ST_ISSUE : ST_DONE;
      ST_ISSUE: if (w_lastIssue) w_nextState = ST_DRAIN;
      ST_DRAIN: if (w_inflight == 0 && w_fifoEmpty) w_nextState = ST_DONE;
      ST_DONE:  w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      ST_ISSUE, ST_DRAIN: o_busy = 1'b1;
      ST_DONE:            o_done = 1'b1;
      default:            o_busy = 1'b0;
    endcase
  end

  // Requantize on the way into the FIFO so the buffer only holds OUT_W-wide rows.
  always_comb begin
    w_reqData = '0;
    w_elem    = '0;
    for (int i = 0; i < BATCH; i++) begin
      w_elem = requant_sat(i_rd_data[i*RES_W +: RES_W], int'(r_shift), OUT_W);
      w_reqData[i*OUT_W +: OUT_W] = w_elem[OUT_W-1:0];
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BATCH*OUT_W)
  ) u_skidFifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_wdata (w_reqData),
    .i_pop   (w_pop),
    .o_rdata (o_out_data),
    .o_empty (w_fifoEmpty),
    .o_count (w_fifoCount)
  );

endmodule

// File: tb/tb_accum_buf_drain.sv
// Bench for accum_buf_drain: requant vector table, directed multi-cycle sequences and
// randomized runs compared against a row-level model built from plain arithmetic.
module tb_accum_buf_drain;

  localparam int DEPTH = 256;
  localparam int BATCH = 4;
  localparam int RES_W = 32;
  localparam int OUT_W = 16;

  typedef struct {
    logic [31:0] x;
    int          sh;
    logic [15:0] y;
  } rq_vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [7:0]   startAddr;
  logic [8:0]   len;
  logic [4:0]   shift;
  logic         busy;
  logic         done;
  logic [7:0]   rdAddr;
  logic [127:0] rdData;
  logic [63:0]  outData;
  logic         outValid;
  logic         outReady;

  logic [127:0] mem [DEPTH];
  logic [63:0]  gotQ[$];
  logic [63:0]  expQ[$];
  int           beatCyc[$];
  int           cyc = 0;
  int           vecCount = 0;
  int           missCount = 0;
  int           doneCnt = 0;
  int           doneBase = 0;
  int           firstValidCyc = -1;
  int           startCyc = 0;
  bit           readyRand = 1'b0;
  rq_vec_t      rqTbl[14];

  always #5 clk = ~clk;

  accum_buf_drain #(
    .DEPTH(256), .RD_LAT(1), .FIFO_DEPTH(3), .OUT_W(16), .SHIFT_W(5)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_start_addr(startAddr), .i_len(len),
    .i_shift(shift), .o_busy(busy), .o_done(done), .o_rd_addr(rdAddr), .i_rd_data(rdData),
    .o_out_data(outData), .o_out_valid(outValid), .i_out_ready(outReady)
  );

  always @(posedge clk) rdData <= mem[rdAddr];
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done) doneCnt++;
    if (outValid && firstValidCyc < 0) firstValidCyc = cyc;
    if (outValid && outReady) begin
      gotQ.push_back(outData);
      beatCyc.push_back(cyc);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (readyRand) outReady = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic longint modelElem(input logic [31:0] raw, input int sh);
    longint x;
    longint y;
    x = longint'($signed(raw));
    if (sh == 0) y = x;
    else         y = (x + (longint'(1) <<< (sh - 1))) >>> sh;
    if (y > 32767)       y = 32767;
    else if (y < -32768) y = -32768;
    return y;
  endfunction

  function automatic logic [63:0] modelRow(input logic [127:0] row, input int sh);
    logic [63:0] r;
    longint      e;
    r = '0;
    for (int i = 0; i < BATCH; i++) begin
      e = modelElem(row[i*RES_W +: RES_W], sh);
      r[i*OUT_W +: OUT_W] = e[15:0];
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    vecCount++;
    if (got !== want) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic startRun(input logic [7:0] sa, input int n, input int sh);
    expQ.delete();
    gotQ.delete();
    beatCyc.delete();
    for (int k = 0; k < n; k++) expQ.push_back(modelRow(mem[(int'(sa) + k) % DEPTH], sh));
    doneBase      = doneCnt;
    firstValidCyc = -1;
    startAddr     = sa;
    len           = 9'(n);
    shift         = 5'(sh);
    start         = 1'b1;
    @(posedge clk);
    #1;
    startCyc = cyc;
    start    = 1'b0;
  endtask

  task automatic finishRun(input string name, input int budget);
    int waited;
    waited = 0;
    while (doneCnt == doneBase && waited < budget) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checkOutput({name, "_doneSeen"}, 64'(doneCnt != doneBase), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput({name, "_doneOnce"}, 64'(doneCnt - doneBase), 64'd1);
    checkOutput({name, "_beats"}, 64'(gotQ.size()), 64'(expQ.size()));
    for (int k = 0; k < expQ.size() && k < gotQ.size(); k++)
      checkOutput($sformatf("%s_row%0d", name, k), gotQ[k], expQ[k]);
  endtask

  task automatic applyStimulus(input string name, input logic [7:0] sa, input int n, input int sh);
    startRun(sa, n, sh);
    finishRun(name, 40 * n + 50);
  endtask

  initial begin
    logic [31:0]        v;
    logic signed [31:0] sv;
    logic [15:0]        e16;
    logic [7:0]         sa;
    logic [7:0]         addrExp;
    logic [7:0]         prevAddr;
    int                 w;

    rqTbl[0]  = '{32'd24,         4,  16'd2};
    rqTbl[1]  = '{32'hFFFF_FFE8,  4,  16'hFFFF};
    rqTbl[2]  = '{32'h7FFF_FFF0,  4,  16'h7FFF};
    rqTbl[3]  = '{32'h8000_0000,  4,  16'h8000};
    rqTbl[4]  = '{32'd5,          0,  16'd5};
    rqTbl[5]  = '{32'h0001_1170,  0,  16'h7FFF};
    rqTbl[6]  = '{32'hFFFE_EE90,  0,  16'h8000};
    rqTbl[7]  = '{32'd8,          4,  16'd1};
    rqTbl[8]  = '{32'd7,          4,  16'd0};
    rqTbl[9]  = '{32'hFFFF_FFF8,  4,  16'd0};
    rqTbl[10] = '{32'hFFFF_FFF7,  4,  16'hFFFF};
    rqTbl[11] = '{32'd1,          31, 16'd0};
    rqTbl[12] = '{32'h8000_0000,  31, 16'hFFFF};
    rqTbl[13] = '{32'h7FFF_FFFF,  31, 16'd1};

    rst = 1'b1; start = 1'b0; startAddr = '0; len = '0; shift = '0; outReady = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      for (int i = 0; i < BATCH; i++) begin
        sv = $urandom;
        sv = sv >>> $urandom_range(0, 28);
        mem[a][i*RES_W +: RES_W] = sv;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstBusy",  64'(busy),     64'd0);
    checkOutput("rstDone",  64'(done),     64'd0);
    checkOutput("rstValid", 64'(outValid), 64'd0);
    checkOutput("rstAddr",  64'(rdAddr),   64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic run: rows hold their own index, unshifted
    for (int i = 0; i < 4; i++) begin
      v = i;
      mem[i] = {4{v}};
    end
    outReady = 1'b1;
    startRun(8'd0, 4, 0);
    finishRun("basic", 100);
    checkOutput("basicLatency", 64'(firstValidCyc - startCyc), 64'd2);
    if (beatCyc.size() >= 4) checkOutput("basicBackToBack", 64'(beatCyc[3] - beatCyc[0]), 64'd3);
    for (int k = 0; k < 4 && k < gotQ.size(); k++) begin
      e16 = 16'(k);
      checkOutput("basicConst", gotQ[k], {4{e16}});
    end

    // Address wrap at the top of the buffer
    startRun(8'd254, 4, 3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      addrExp = 8'(254 + k);
      checkOutput($sformatf("wrapAddr%0d", k), 64'(rdAddr), 64'(addrExp));
    end
    @(posedge clk);
    #1;
    finishRun("wrap", 100);

    // Backpressure: only FIFO_DEPTH reads may go out while stalled
    outReady = 1'b0;
    sa = 8'd250;
    startRun(sa, 8, 2);
    addrExp = sa + 8'd3;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("bpAddrEarly", 64'(rdAddr), 64'(addrExp));
    checkOutput("bpValid", 64'(outValid), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("bpAddrFrozen", 64'(rdAddr), 64'(addrExp));
    checkOutput("bpNoBeats", 64'(gotQ.size()), 64'd0);
    outReady = 1'b1;
    finishRun("bp", 200);

    // Zero-length command
    prevAddr = rdAddr;
    startRun(8'd77, 0, 0);
    @(negedge clk);
    checkOutput("len0Done", 64'(done), 64'd1);
    checkOutput("len0Busy", 64'(busy), 64'd0);
    checkOutput("len0Addr", 64'(rdAddr), 64'(prevAddr));
    @(posedge clk);
    #1;
    finishRun("len0", 20);
    checkOutput("len0NoValid", 64'(firstValidCyc == -1), 64'd1);

    // Second start while busy must be ignored
    startRun(8'd10, 5, 1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("ignBusy", 64'(busy), 64'd1);
    start = 1'b1; startAddr = 8'd100; len = 9'd9; shift = 5'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    finishRun("ignore", 150);

    // Reset in the middle of a run
    startRun(8'd40, 6, 0);
    w = 0;
    while (gotQ.size() < 3 && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    checkOutput("rstMidReach3", 64'(gotQ.size() >= 3), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rstMidValid", 64'(outValid), 64'd0);
    checkOutput("rstMidBusy",  64'(busy),     64'd0);
    doneBase = doneCnt;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("rstMidNoDone", 64'(doneCnt - doneBase), 64'd0);
    applyStimulus("postRst", 8'd5, 2, 0);

    // Requantization table, one single-row run per vector
    for (int i = 0; i < 14; i++) begin
      mem[200] = {4{rqTbl[i].x}};
      startRun(8'd200, 1, rqTbl[i].sh);
      finishRun("rq", 30);
      if (gotQ.size() > 0) checkOutput($sformatf("rqTable%0d", i), gotQ[0], {4{rqTbl[i].y}});
    end

    // Randomized runs with random downstream stalls
    readyRand = 1'b1;
    for (int r = 0; r < 20; r++)
      applyStimulus("rand", 8'($urandom_range(0, 255)), $urandom_range(1, 20), $urandom_range(0, 31));
    applyStimulus("fullDepth", 8'd100, DEPTH, 6);
    readyRand = 1'b0;
    outReady  = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
